// File: rtl/div_pkg.sv
// Shared types and constants for the execute-stage radix-2 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  localparam int unsigned DIV_STEPS     = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/divider_if.sv
// Pipeline <-> divider handshake: operands and control in, stall/ready/{HI,LO} result out.
interface divider_if
  import div_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_STEPS
);

  logic               div_start;
  logic               div_signed;
  logic [DIV_W-1:0]   opdata1;
  logic [DIV_W-1:0]   opdata2;
  logic               annul;
  logic               hold;
  logic               stall_div;
  logic               ready;
  logic [2*DIV_W-1:0] result;

  modport master (
    output div_start, div_signed, opdata1, opdata2, annul, hold,
    input  stall_div, ready, result
  );

  modport slave (
    input  div_start, div_signed, opdata1, opdata2, annul, hold,
    output stall_div, ready, result
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, try subtracting the divisor.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W:0]   rem,
  input  logic         dividendBit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   remNext,
  output logic         quotBit
);

  logic [W+1:0] trial;

  always_comb begin
    // One extra bit so the borrow of the trial subtraction is observable as the MSB.
    trial   = {rem, dividendBit} - {2'b00, divisor};
    quotBit = ~trial[W+1];
    remNext = quotBit ? trial[W:0] : {rem[W-1:0], dividendBit};
  end

endmodule

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result = {remainder, quotient} for HI/LO.
// Optional DIV_FAST_PATH_EN: finish in one cycle when |dividend| < |divisor|.
module divider
  import div_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_STEPS
) (
  input  logic      clk,
  input  logic      rst,
  divider_if.slave  bus
);

  localparam logic [5:0] LAST_STEP = 6'(DIV_W - 1);

  div_state_e         state;
  logic [5:0]         cnt;
  logic [DIV_W:0]     remReg;
  logic [DIV_W-1:0]   dvdReg;
  logic [DIV_W-1:0]   dsrReg;
  logic               quotNeg;
  logic               remNeg;
  logic [2*DIV_W-1:0] resultReg;
  logic               readyReg;

  logic               aNeg;
  logic               bNeg;
  logic [DIV_W-1:0]   absA;
  logic [DIV_W-1:0]   absB;
  logic [DIV_W:0]     stepRem;
  logic               stepQ;
  logic [DIV_W-1:0]   quotMag;
  logic [DIV_W-1:0]   quotFix;
  logic [DIV_W-1:0]   remFix;

  div_step #(.W(DIV_W)) u_step (
    .rem         (remReg),
    .dividendBit (dvdReg[DIV_W-1]),
    .divisor     (dsrReg),
    .remNext     (stepRem),
    .quotBit     (stepQ)
  );

  always_comb begin
    aNeg    = bus.div_signed & bus.opdata1[DIV_W-1];
    bNeg    = bus.div_signed & bus.opdata2[DIV_W-1];
    absA    = aNeg ? -bus.opdata1 : bus.opdata1;
    absB    = bNeg ? -bus.opdata2 : bus.opdata2;
    // Final step result is used directly so the sign fix lands on the same edge.
    quotMag = {dvdReg[DIV_W-2:0], stepQ};
    quotFix = quotNeg ? -quotMag : quotMag;
    remFix  = remNeg ? -stepRem[DIV_W-1:0] : stepRem[DIV_W-1:0];
  end

  always_comb begin
    bus.stall_div = bus.div_start & ~bus.annul &
                    ((state == DIV_IDLE) | (state == DIV_BUSY));
    bus.ready     = readyReg;
    bus.result    = resultReg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      remReg    <= '0;
      dvdReg    <= '0;
      dsrReg    <= '0;
      quotNeg   <= 1'b0;
      remNeg    <= 1'b0;
      resultReg <= '0;
      readyReg  <= 1'b0;
    end else if (bus.annul) begin
      state    <= DIV_IDLE;
      readyReg <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (bus.div_start) begin
            dvdReg  <= absA;
            dsrReg  <= absB;
            quotNeg <= aNeg ^ bNeg;
            remNeg  <= aNeg;
            if (absB == '0) begin
              resultReg <= {bus.opdata1, DIV_W'(DIV_ZERO_QUOT)};
              readyReg  <= 1'b1;
              state     <= DIV_DONE;
            end
`ifdef DIV_FAST_PATH_EN
            else if (absA < absB) begin
              resultReg <= {bus.opdata1, {DIV_W{1'b0}}};
              readyReg  <= 1'b1;
              state     <= DIV_DONE;
            end
`endif
            else begin
              cnt    <= '0;
              remReg <= '0;
              state  <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          remReg <= stepRem;
          dvdReg <= quotMag;
          cnt    <= cnt + 6'd1;
          if (cnt == LAST_STEP) begin
            resultReg <= {remFix, quotFix};
            readyReg  <= 1'b1;
            state     <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (!bus.hold) begin
            readyReg <= 1'b0;
            state    <= DIV_IDLE;
          end
        end
        default: begin
          readyReg <= 1'b0;
          state    <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for divider: latency, stall count, results, annul/reset/hold behaviour.
module tb_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned nChecks = 0;
  int unsigned nFails  = 0;

  divider_if #(.DIV_W(32)) bus ();

  divider #(.DIV_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 of the IDLE cycle T; returns at posedge+1 of the cycle ready rises.
  task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expRes,
                        input int unsigned expLat, input bit scramble);
    int unsigned lat = 0;
    int unsigned stalls = 0;
    bit done = 1'b0;
    bus.div_start  = 1'b1;
    bus.div_signed = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    while (!done && lat < 100) begin
      @(negedge clk);
      if (bus.stall_div) stalls++;
      @(posedge clk);
      #1;
      lat++;
      if (bus.ready) done = 1'b1;
      if (scramble && lat == 1) begin
        bus.opdata1 = $urandom;
        bus.opdata2 = $urandom;
      end
      if (scramble && lat == 5)  bus.hold = 1'b1;
      if (scramble && lat == 20) bus.hold = 1'b0;
    end
    checkVal({tag, "/lat"}, 64'(lat), 64'(expLat));
    checkVal({tag, "/stalls"}, 64'(stalls), 64'(expLat));
    checkVal({tag, "/result"}, bus.result, expRes);
  endtask

  // DONE cycle with hold low: no stall, then the instruction leaves E.
  task automatic endDiv(input string tag);
    @(negedge clk);
    checkVal({tag, "/doneStall"}, 64'(bus.stall_div), 64'd0);
    @(posedge clk);
    #1;
    bus.div_start = 1'b0;
  endtask

  initial begin
    int unsigned fastLat;
`ifdef DIV_FAST_PATH_EN
    fastLat = 1;
`else
    fastLat = 33;
`endif
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.annul      = 1'b0;
    bus.hold       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkVal("rst/ready", 64'(bus.ready), 64'd0);
    checkVal("rst/stall", 64'(bus.stall_div), 64'd0);
    checkVal("rst/result", bus.result, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    runDiv("divu7_2", 1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 33, 1'b0);
    endDiv("divu7_2");

    // Reset in the middle of a division wipes everything back to reset values.
    bus.div_start = 1'b1; bus.div_signed = 1'b0;
    bus.opdata1 = 32'd100; bus.opdata2 = 32'd7;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    bus.div_start = 1'b0;
    #1;
    checkVal("rstBusy/ready", 64'(bus.ready), 64'd0);
    checkVal("rstBusy/result", bus.result, 64'd0);
    checkVal("rstBusy/stall", 64'(bus.stall_div), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    runDiv("divNeg7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
    endDiv("divNeg7_2");
    runDiv("divOvf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1'b0);
    endDiv("divOvf");
    runDiv("div7_neg2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1'b0);
    endDiv("div7_neg2");
    runDiv("divNegNeg", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33, 1'b0);
    endDiv("divNegNeg");
    runDiv("divuMax_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, 1'b0);
    endDiv("divuMax_1");
    runDiv("divuZero", 1'b0, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF, 1, 1'b0);
    endDiv("divuZero");
    runDiv("divZeroNeg", 1'b1, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 1, 1'b0);
    endDiv("divZeroNeg");
    runDiv("divuScramble", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b1);
    endDiv("divuScramble");

    // Annul at T+10: stall drops at once, no ready, old result kept.
    bus.div_start = 1'b1; bus.div_signed = 1'b0;
    bus.opdata1 = 32'd50; bus.opdata2 = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    bus.annul = 1'b1;
    #3;
    checkVal("annul/stall", 64'(bus.stall_div), 64'd0);
    @(posedge clk); #1;
    bus.annul = 1'b0;
    bus.div_start = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ready) break;
    end
    checkVal("annul/noReady", 64'(bus.ready), 64'd0);
    checkVal("annul/result", bus.result, 64'h00000002_0000000E);
    runDiv("afterAnnul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0);
    endDiv("afterAnnul");

    // Annul together with start in IDLE must not capture (a /0 capture would be ready next cycle).
    bus.div_start = 1'b1; bus.annul = 1'b1;
    bus.opdata1 = 32'd5; bus.opdata2 = 32'd0;
    #3;
    checkVal("annulIdle/stall", 64'(bus.stall_div), 64'd0);
    @(posedge clk); #1;
    bus.div_start = 1'b0; bus.annul = 1'b0;
    checkVal("annulIdle/ready", 64'(bus.ready), 64'd0);
    @(posedge clk); #1;
    checkVal("annulIdle/ready2", 64'(bus.ready), 64'd0);

    // Hold for 3 cycles in DONE, then a back-to-back DIV in the following IDLE cycle.
    runDiv("hold", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 33, 1'b0);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 2) bus.hold = 1'b0;
      checkVal($sformatf("hold/ready%0d", i), 64'(bus.ready), 64'd1);
      checkVal($sformatf("hold/result%0d", i), bus.result, 64'h00000000_00000064);
    end
    @(posedge clk); #1;
    runDiv("b2b", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33, 1'b0);
    endDiv("b2b");

    runDiv("fast3_10", 1'b0, 32'd3, 32'd10, 64'h00000003_00000000, fastLat, 1'b0);
    endDiv("fast3_10");
    runDiv("fastUnsBig", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, fastLat, 1'b0);
    endDiv("fastUnsBig");
    runDiv("fastSigned", 1'b1, 32'hFFFFFFFD, 32'd10, 64'hFFFFFFFD_00000000, fastLat, 1'b0);
    endDiv("fastSigned");

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
